// File: rtl/bcd_scan_counter.sv
// Two-digit BCD up/down counter with button synchronisers and a
// free-running scan divider that drives a 2:1 digit selector.
module bcd_scan_counter #(
  parameter int SCAN_DIV  = 50000,
  parameter int MAX_COUNT = 99,
  parameter bit BLANK_LZ  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  output logic [3:0] ones_bcd,
  output logic [3:0] tens_bcd,
  output logic       digit_sel,
  output logic       blank,
  output logic       wrap
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0] MAX_T = 4'(MAX_COUNT / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_COUNT % 10);

  logic [1:0]    inc_sync_q, dec_sync_q;
  logic          inc_hist_q, dec_hist_q;
  logic          inc_pulse, dec_pulse;
  logic          step_up, step_dn;
  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_q, tens_d;
  logic          wrap_q, wrap_d;
  logic [DW-1:0] div_q, div_d;
  logic          sel_q, sel_d;
  logic          at_max, at_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_sync_q <= '0;
      dec_sync_q <= '0;
      inc_hist_q <= 1'b0;
      dec_hist_q <= 1'b0;
    end else begin
      inc_sync_q <= {inc_sync_q[0], inc};
      dec_sync_q <= {dec_sync_q[0], dec};
      inc_hist_q <= inc_sync_q[1];
      dec_hist_q <= dec_sync_q[1];
    end
  end

  assign inc_pulse = inc_sync_q[1] & ~inc_hist_q;
  assign dec_pulse = dec_sync_q[1] & ~dec_hist_q;
  // Simultaneous presses cancel out
  assign step_up   = inc_pulse & ~dec_pulse;
  assign step_dn   = dec_pulse & ~inc_pulse;
  assign at_max    = (ones_q == MAX_O) && (tens_q == MAX_T);
  assign at_zero   = (ones_q == 4'd0) && (tens_q == 4'd0);

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    wrap_d = 1'b0;
    if (clr) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (step_up) begin
      if (at_max) begin
        ones_d = 4'd0;
        tens_d = 4'd0;
        wrap_d = 1'b1;
      end else if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (step_dn) begin
      if (at_zero) begin
        ones_d = MAX_O;
        tens_d = MAX_T;
        wrap_d = 1'b1;
      end else if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_comb begin
    div_d = div_q + 1'b1;
    sel_d = sel_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      sel_d = ~sel_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
      wrap_q <= 1'b0;
      div_q  <= '0;
      sel_q  <= 1'b0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
      wrap_q <= wrap_d;
      div_q  <= div_d;
      sel_q  <= sel_d;
    end
  end

  assign ones_bcd  = ones_q;
  assign tens_bcd  = tens_q;
  assign wrap      = wrap_q;
  assign digit_sel = sel_q;
  assign blank     = BLANK_LZ & sel_q & (tens_q == 4'd0);

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter: MAX 99 and MAX 59
// instances, both with a 4-cycle scan divider.
module tb_bcd_scan_counter;

  logic clk = 1'b0;
  logic rst_n;
  logic inc, dec, clr;
  logic inc59, dec59, clr59;
  logic [3:0] ones, tens, ones59, tens59;
  logic sel, blank, wrap, sel59, blank59, wrap59;
  int checks = 0;
  int errors = 0;
  int cyc;
  logic [3:0] po [2];
  logic [3:0] pt [2];

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  bcd_scan_counter #(
    .SCAN_DIV(4), .MAX_COUNT(99), .BLANK_LZ(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .clr(clr),
    .ones_bcd(ones), .tens_bcd(tens), .digit_sel(sel),
    .blank(blank), .wrap(wrap)
  );

  bcd_scan_counter #(
    .SCAN_DIV(4), .MAX_COUNT(59), .BLANK_LZ(1'b1)
  ) dut59 (
    .clk(clk), .rst_n(rst_n), .inc(inc59), .dec(dec59),
    .clr(clr59), .ones_bcd(ones59), .tens_bcd(tens59),
    .digit_sel(sel59), .blank(blank59), .wrap(wrap59)
  );

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input bit w,
                         input logic [3:0] eo,
                         input logic [3:0] et,
                         input logic ew);
    logic [7:0] c;
    logic       wr;
    c  = w ? {tens59, ones59} : {tens, ones};
    wr = w ? wrap59 : wrap;
    check({tag, "_cnt"}, c, {et, eo});
    check({tag, "_wrap"}, 8'(wr), 8'(ew));
  endtask

  task automatic drive(input bit w, input bit u, input bit d);
    if (w) begin
      inc59 = u;
      dec59 = d;
    end else begin
      inc = u;
      dec = d;
    end
  endtask

  // Press at a negedge; sampled at edge N, lands at edge N+2
  task automatic step(input string tag, input bit u, input bit d,
                      input logic [3:0] eo, input logic [3:0] et,
                      input logic ew, input bit w);
    drive(w, u, d);
    @(negedge clk);
    @(negedge clk);
    chk_cnt({tag, "_hold"}, w, po[w], pt[w], 1'b0);
    @(negedge clk);
    chk_cnt(tag, w, eo, et, ew);
    drive(w, 1'b0, 1'b0);
    @(negedge clk);
    chk_cnt({tag, "_post"}, w, eo, et, 1'b0);
    repeat (2) @(negedge clk);
    po[w] = eo;
    pt[w] = et;
  endtask

  task automatic scan_blank(input string tag, input logic eb);
    logic es;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      es = ((cyc / 4) % 2) == 1;
      check({tag, "_sel"}, 8'(sel), 8'(es));
      check({tag, "_blank"}, 8'(blank), 8'(es & eb));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {inc, dec, clr, inc59, dec59, clr59} = '0;
    po[0] = 4'd0; pt[0] = 4'd0;
    po[1] = 4'd0; pt[1] = 4'd0;
    repeat (2) @(negedge clk);
    chk_cnt("rst", 1'b0, 4'd0, 4'd0, 1'b0);
    check("rst_sel", 8'(sel), 8'd0);
    check("rst_blank", 8'(blank), 8'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      check($sformatf("scan_e%0d", k), 8'(sel), 8'((k / 4) % 2));
    end

    step("inc1", 1, 0, 4'd1, 4'd0, 1'b0, 1'b0);
    step("inc2", 1, 0, 4'd2, 4'd0, 1'b0, 1'b0);
    step("inc3", 1, 0, 4'd3, 4'd0, 1'b0, 1'b0);
    step("inc4", 1, 0, 4'd4, 4'd0, 1'b0, 1'b0);
    step("inc5", 1, 0, 4'd5, 4'd0, 1'b0, 1'b0);
    step("inc6", 1, 0, 4'd6, 4'd0, 1'b0, 1'b0);
    step("inc7", 1, 0, 4'd7, 4'd0, 1'b0, 1'b0);
    step("inc8", 1, 0, 4'd8, 4'd0, 1'b0, 1'b0);
    step("inc9", 1, 0, 4'd9, 4'd0, 1'b0, 1'b0);
    step("inc10", 1, 0, 4'd0, 4'd1, 1'b0, 1'b0);
    scan_blank("at10", 1'b0);

    step("dec09", 0, 1, 4'd9, 4'd0, 1'b0, 1'b0);
    step("dec08", 0, 1, 4'd8, 4'd0, 1'b0, 1'b0);
    step("dec07", 0, 1, 4'd7, 4'd0, 1'b0, 1'b0);
    scan_blank("at07", 1'b1);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk_cnt("clr07", 1'b0, 4'd0, 4'd0, 1'b0);
    po[0] = 4'd0; pt[0] = 4'd0;
    repeat (2) @(negedge clk);

    step("dec_wrap", 0, 1, 4'd9, 4'd9, 1'b1, 1'b0);
    step("inc_wrap", 1, 0, 4'd0, 4'd0, 1'b1, 1'b0);
    step("both", 1, 1, 4'd0, 4'd0, 1'b0, 1'b0);

    inc = 1'b1;
    repeat (100) @(negedge clk);
    chk_cnt("held100", 1'b0, 4'd1, 4'd0, 1'b0);
    inc = 1'b0;
    repeat (3) @(negedge clk);

    inc = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk_cnt("clr_pulse", 1'b0, 4'd0, 4'd0, 1'b0);
    clr = 1'b0;
    inc = 1'b0;
    repeat (4) @(negedge clk);
    chk_cnt("clr_after", 1'b0, 4'd0, 4'd0, 1'b0);
    po[0] = 4'd0; pt[0] = 4'd0;

    step("m59_dec", 0, 1, 4'd9, 4'd5, 1'b1, 1'b1);
    step("m59_inc", 1, 0, 4'd0, 4'd0, 1'b1, 1'b1);

    step("pre_rst", 1, 0, 4'd1, 4'd0, 1'b0, 1'b0);
    inc = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_cnt("mid_rst", 1'b0, 4'd0, 4'd0, 1'b0);
    check("mid_rst_sel", 8'(sel), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_cnt("rel_e2", 1'b0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    chk_cnt("rel_e3", 1'b0, 4'd1, 4'd0, 1'b0);
    inc = 1'b0;
    repeat (4) @(negedge clk);
    chk_cnt("rel_hold", 1'b0, 4'd1, 4'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
